rf_scoreboard: RTL

Parametrised multi-port register file with an integrated pending-write scoreboard for the pipelined MIPS datapath. Provides two asynchronous read ports and one synchronous write port, with register 0 hardwired to zero. Each register also carries a pending bit that issue sets and writeback clears, so decode can detect RAW hazards without a separate hazard table. Sits between decode (read/reserve) and writeback (write/release).

---
 rtl/rf_scoreboard.sv | 87 ++++++++
 1 files changed

// File: rtl/rf_scoreboard.sv
// Register file (2 async read, 1 sync write, r0 = 0) with a per-register pending scoreboard and registered pending count.
// Optional RF_BYPASS_EN macro forwards same-cycle write data/pending state to the read ports.
module rf_scoreboard #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int INIT_STEP = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] r_register01,
  input  logic [ADDR_W-1:0] r_register02,
  output logic [DATA_W-1:0] r_data01,
  output logic [DATA_W-1:0] r_data02,
  output logic              r_pend01,
  output logic              r_pend02,
  input  logic              r_wrt,
  input  logic [ADDR_W-1:0] wrt_register,
  input  logic [DATA_W-1:0] wrt_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_register,
  input  logic              flush,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic [DEPTH-1:0]  pend_nxt;
  logic              wr_hit;
  logic              rsv_hit;

  function automatic logic [DATA_W-1:0] init_val(input int idx);
    logic [63:0] prod;
    prod = 64'(idx) * 64'(INIT_STEP);
    return prod[DATA_W-1:0];
  endfunction

  function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
    logic [ADDR_W:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) c = c + (ADDR_W+1)'(v[i]);
    return c;
  endfunction

  assign wr_hit  = r_wrt && (wrt_register != '0);
  assign rsv_hit = rsv_en && (rsv_register != '0);

  // Later assignments win: flush over reserve over write-clear.
  always_comb begin
    pend_nxt = pend;
    if (wr_hit) pend_nxt[wrt_register] = 1'b0;
    if (flush) pend_nxt = '0;
    else if (rsv_hit) pend_nxt[rsv_register] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      if (wr_hit) mem[wrt_register] <= wrt_data;
      pend     <= pend_nxt;
      pend_cnt <= popcount(pend_nxt);
    end
  end

  always_comb begin
    r_data01 = (r_register01 == '0) ? '0 : mem[r_register01];
    r_data02 = (r_register02 == '0) ? '0 : mem[r_register02];
    r_pend01 = pend[r_register01];
    r_pend02 = pend[r_register02];
`ifdef RF_BYPASS_EN
    if (wr_hit && (wrt_register == r_register01)) begin
      r_data01 = wrt_data;
      r_pend01 = rsv_en && (rsv_register == r_register01);
    end
    if (wr_hit && (wrt_register == r_register02)) begin
      r_data02 = wrt_data;
      r_pend02 = rsv_en && (rsv_register == r_register02);
    end
`endif
  end

endmodule
